// File: rtl/dmem_responder.sv
// Multi-cycle doubleword data memory: accepts one request in IDLE, responds LATENCY+1 cycles later.
// req_ready is low from acceptance through the response pulse; misaligned/out-of-range accesses only flag rsp_err.
module dmem_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          cap_write;
  logic [63:0]   cap_addr;
  logic [63:0]   cap_wdata;
  logic          access;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [7:0]    mem [DEPTH_BYTES];

  // Range check runs on all 64 address bits so high aliases cannot slip through.
  assign acc_err = (cap_addr[2:0] != 3'b000) || (cap_addr > 64'(DEPTH_BYTES - 8));
  assign idx     = cap_addr[AW-1:0];

  assign req_ready = (state == S_IDLE) && !reset;
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      S_IDLE: if (req_valid) state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 64'd0;
      cap_wdata <= 64'd0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'd0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= 64'd0;
        if (!acc_err) begin
          if (cap_write) begin
            for (int k = 0; k < 8; k++) mem[idx + AW'(k)] <= cap_wdata[8*k +: 8];
          end else begin
            for (int k = 0; k < 8; k++) rsp_rdata[8*k +: 8] <= mem[idx + AW'(k)];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two builds (LATENCY 2 and 1) checked against a byte-array model every cycle.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv [2];
  logic        rw [2];
  logic [63:0] ra [2];
  logic [63:0] rwd [2];
  logic        rr [2];
  logic        vld [2];
  logic [63:0] rd [2];
  logic        er [2];

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rr[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]),
    .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(er[0])
  );

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rr[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]),
    .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(er[1])
  );

  // Model: each instance is either counting edges to its access, showing a response, or idle.
  int          m_left [2] = '{0, 0};
  logic        m_vld [2] = '{1'b0, 1'b0};
  logic [63:0] m_rdata [2];
  logic        m_err [2];
  logic        m_w [2];
  logic [63:0] m_a [2];
  logic [63:0] m_wd [2];
  logic [7:0]  m_mem [2][DEPTH];
  logic        m_resp_edge;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic model_access(input int i);
    logic [63:0] a;
    int base;
    a = m_a[i];
    m_rdata[i] = 64'd0;
    m_err[i] = (a[2:0] != 3'b000) || (a > 64'(DEPTH - 8));
    if (!m_err[i]) begin
      base = int'(a[7:0]);
      for (int k = 0; k < 8; k++) begin
        if (m_w[i]) m_mem[i][base + k] = m_wd[i][8*k +: 8];
        else        m_rdata[i][8*k +: 8] = m_mem[i][base + k];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_left[i]  = 0;
        m_vld[i]   = 1'b0;
        m_rdata[i] = 64'd0;
        m_err[i]   = 1'b0;
        for (int j = 0; j < DEPTH; j++) m_mem[i][j] = 8'd0;
      end else begin
        m_resp_edge = m_vld[i];
        m_vld[i] = 1'b0;
        if (m_left[i] > 0) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            model_access(i);
            m_vld[i] = 1'b1;
          end
        end else if (!m_resp_edge && rv[i]) begin
          m_w[i]    = rw[i];
          m_a[i]    = ra[i];
          m_wd[i]   = rwd[i];
          m_left[i] = lat_of(i);
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] @%0t got %h want %h", nm, i, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("req_ready", i, 64'(rr[i]), 64'(!reset && m_left[i] == 0 && !m_vld[i]));
      chk("rsp_valid", i, 64'(vld[i]), 64'(m_vld[i]));
      if (m_vld[i]) begin
        chk("model_rdata", i, rd[i], m_rdata[i]);
        chk("model_err", i, 64'(er[i]), 64'(m_err[i]));
      end
    end
  end

  task automatic do_req(input int i, input logic w, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] x_rdata, input logic x_err, input int x_lat);
    logic ok;
    int lat;
    @(posedge clk); #1;
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; rwd[i] = wd;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rr[i]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    rv[i] = 1'b0;
    chk("accept", i, 64'(ok), 64'd1);
    ok = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (vld[i]) begin ok = 1'b1; lat = n; break; end
    end
    chk("rsp_seen", i, 64'(ok), 64'd1);
    chk("latency", i, 64'(lat), 64'(x_lat));
    chk("rdata", i, rd[i], x_rdata);
    chk("err", i, 64'(er[i]), 64'(x_err));
  endtask

  initial begin
    int nr;
    int nv;
    logic ok;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 64'd0; rwd[i] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 64'(rr[i]), 64'd1);
      chk("rst_valid", i, 64'(vld[i]), 64'd0);
      chk("rst_rdata", i, rd[i], 64'd0);
      chk("rst_err", i, 64'(er[i]), 64'd0);
    end

    do_req(0, 1'b1, 64'h10, 64'h1122334455667788, 64'd0, 1'b0, 3);
    do_req(0, 1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 3);
    do_req(0, 1'b0, 64'h08, 64'd0, 64'd0, 1'b0, 3);
    do_req(0, 1'b0, 64'h18, 64'd0, 64'd0, 1'b0, 3);
    do_req(0, 1'b1, 64'h10, 64'h00000000000000FF, 64'd0, 1'b0, 3);
    do_req(0, 1'b0, 64'h10, 64'd0, 64'hFF, 1'b0, 3);
    do_req(0, 1'b0, 64'h13, 64'd0, 64'd0, 1'b1, 3);
    do_req(0, 1'b1, 64'hF9, 64'hCAFEF00DCAFEF00D, 64'd0, 1'b1, 3);
    do_req(0, 1'b0, 64'hF8, 64'd0, 64'd0, 1'b0, 3);
    do_req(0, 1'b0, 64'h1_0000_0000, 64'd0, 64'd0, 1'b1, 3);
    do_req(0, 1'b1, 64'h1_0000_0010, 64'h5555, 64'd0, 1'b1, 3);
    do_req(0, 1'b0, 64'h10, 64'd0, 64'hFF, 1'b0, 3);
    do_req(0, 1'b1, 64'hF8, 64'hA5A5A5A55A5A5A5A, 64'd0, 1'b0, 3);
    do_req(0, 1'b0, 64'hF8, 64'd0, 64'hA5A5A5A55A5A5A5A, 1'b0, 3);
    do_req(0, 1'b0, 64'h100, 64'd0, 64'd0, 1'b1, 3);

    // Back-to-back loads with req_valid held high.
    @(posedge clk); #1;
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 64'h10;
    nr = 0; nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (rr[0]) nr++;
      if (vld[0]) nv++;
    end
    rv[0] = 1'b0;
    chk("hold_ready_pulses", 0, 64'(nr), 64'd3);
    chk("hold_rsp_pulses", 0, 64'(nv), 64'd3);

    // Store aborted by reset one cycle after acceptance.
    @(posedge clk); #1;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h20; rwd[0] = 64'hDEADBEEF;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rr[0]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    rv[0] = 1'b0;
    reset = 1'b1;
    chk("abort_accept", 0, 64'(ok), 64'd1);
    nv = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (vld[0]) nv++;
      if (n == 2) reset = 1'b0;
    end
    chk("abort_no_rsp", 0, 64'(nv), 64'd0);
    do_req(0, 1'b0, 64'h20, 64'd0, 64'd0, 1'b0, 3);

    do_req(1, 1'b1, 64'h00, 64'h0123456789ABCDEF, 64'd0, 1'b0, 2);
    do_req(1, 1'b0, 64'h00, 64'd0, 64'h0123456789ABCDEF, 1'b0, 2);
    do_req(1, 1'b0, 64'hF9, 64'd0, 64'd0, 1'b1, 2);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
